// File: rtl/gx_reset_pkg.sv
// Shared types and helpers for the gx_reset_seq_xn transceiver reset sequencer.
// Holds the TX/RX state encodings and the counter-width helpers used by both FSMs.
package gx_reset_pkg;

    typedef enum logic [1:0] {
        T_ANALOG   = 2'd0,
        T_WAIT_CAL = 2'd1,
        T_WAIT_DIG = 2'd2,
        T_READY    = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_ANALOG   = 2'd0,
        R_WAIT_CAL = 2'd1,
        R_WAIT_LTD = 2'd2,
        R_READY    = 2'd3
    } rx_state_t;

    localparam int RELOCK_W = 8;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gx_rx_reset_fsm.sv
// One RX channel reset FSM with its phase counter (analog hold, cal wait, lock-to-data qualify).
// With GX_RESET_RELOCK_EN a lock loss in R_READY re-runs the full sequence and is counted.
module gx_rx_reset_fsm
    import gx_reset_pkg::*;
#(
    parameter int T_ANALOG_CYC = 100,
    parameter int T_LTD_CYC    = 400
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_reset_req,
    input  logic                i_cal_busy,
    input  logic                i_locked,
    output logic                o_analogreset,
    output logic                o_digitalreset,
    output logic                o_ready
`ifdef GX_RESET_RELOCK_EN
    ,
    output logic [RELOCK_W-1:0] o_relock_cnt
`endif
);

    localparam int                CNT_W    = cnt_width(max2(T_ANALOG_CYC, T_LTD_CYC));
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(max2(T_ANALOG_CYC, T_LTD_CYC));
    localparam logic [CNT_W-1:0]  ANA_TERM = CNT_W'(T_ANALOG_CYC);
    localparam logic [CNT_W-1:0]  LTD_TERM = CNT_W'(T_LTD_CYC);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_analog;
    logic             r_digital;
    logic             r_ready;
`ifdef GX_RESET_RELOCK_EN
    logic             w_relock_evt;
`endif

    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
`ifdef GX_RESET_RELOCK_EN
        w_relock_evt = 1'b0;
`endif
        if (i_reset_req) begin
            w_state_nxt = R_ANALOG;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                R_ANALOG: begin
                    if (w_cnt_inc == ANA_TERM) begin
                        w_state_nxt = R_WAIT_CAL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                R_WAIT_CAL: begin
                    if (!i_cal_busy) begin
                        w_state_nxt = R_WAIT_LTD;
                        w_cnt_nxt   = '0;
                    end
                end
                R_WAIT_LTD: begin
                    if (!i_locked) begin
                        w_cnt_nxt = '0;
                    end else if (w_cnt_inc == LTD_TERM) begin
                        w_state_nxt = R_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                R_READY: begin
                    if (!i_locked) begin
`ifdef GX_RESET_RELOCK_EN
                        w_state_nxt  = R_ANALOG;
                        w_relock_evt = 1'b1;
`else
                        w_state_nxt  = R_WAIT_LTD;
`endif
                        w_cnt_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt = R_ANALOG;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= R_ANALOG;
            r_cnt     <= '0;
            r_analog  <= 1'b1;
            r_digital <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_analog  <= (w_state_nxt == R_ANALOG);
            r_digital <= (w_state_nxt != R_READY);
            r_ready   <= (w_state_nxt == R_READY);
        end
    end

`ifdef GX_RESET_RELOCK_EN
    logic [RELOCK_W-1:0] r_relock_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_relock_cnt <= '0;
        end else if (w_relock_evt && (r_relock_cnt != '1)) begin
            r_relock_cnt <= r_relock_cnt + RELOCK_W'(1);
        end
    end

    assign o_relock_cnt = r_relock_cnt;
`endif

    assign o_analogreset  = r_analog;
    assign o_digitalreset = r_digital;
    assign o_ready        = r_ready;

endmodule

// File: rtl/gx_reset_seq_xn.sv
// N-channel transceiver reset sequencer: bonded TX FSM and status synchronisers here, RX FSMs per channel.
// Optional GX_RESET_RELOCK_EN: full RX re-sequence on lock loss and adds rx_relock_cnt.
module gx_reset_seq_xn
    import gx_reset_pkg::*;
#(
    parameter int NUM_CH       = 6,
    parameter int T_ANALOG_CYC = 100,
    parameter int T_DIG_CYC    = 50,
    parameter int T_LTD_CYC    = 400,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  reconfig_clk,
    input  logic                  reconfig_reset,
    input  logic                  tx_reset_req,
    input  logic [NUM_CH-1:0]     rx_reset_req,
    input  logic                  tx_pll_locked,
    input  logic [NUM_CH-1:0]     tx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_is_lockedtodata,
    output logic [NUM_CH-1:0]     tx_analogreset,
    output logic [NUM_CH-1:0]     tx_digitalreset,
    output logic [NUM_CH-1:0]     rx_analogreset,
    output logic [NUM_CH-1:0]     rx_digitalreset,
    output logic                  tx_ready,
    output logic [NUM_CH-1:0]     rx_ready
`ifdef GX_RESET_RELOCK_EN
    ,
    output logic [8*NUM_CH-1:0]   rx_relock_cnt
`endif
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int STAT_W = 1 + 3 * NUM_CH;

    localparam int                  TX_CNT_W = cnt_width(max2(T_ANALOG_CYC, T_DIG_CYC));
    localparam logic [TX_CNT_W-1:0] TX_SAT   = TX_CNT_W'(max2(T_ANALOG_CYC, T_DIG_CYC));
    localparam logic [TX_CNT_W-1:0] ANA_TERM = TX_CNT_W'(T_ANALOG_CYC);
    localparam logic [TX_CNT_W-1:0] DIG_TERM = TX_CNT_W'(T_DIG_CYC);

    logic [STAT_W-1:0] r_sync [SYNC_N];
    logic              w_pll_locked;
    logic [NUM_CH-1:0] w_tx_cal_busy;
    logic [NUM_CH-1:0] w_rx_cal_busy;
    logic [NUM_CH-1:0] w_rx_ltd;

    // NOTE: synchroniser flops are deliberately not reset; they flush within SYNC_N cycles.
    always_ff @(posedge reconfig_clk) begin
        r_sync[0] <= {tx_pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata};
        for (int i = 1; i < SYNC_N; i++) begin
            r_sync[i] <= r_sync[i-1];
        end
    end

    assign {w_pll_locked, w_tx_cal_busy, w_rx_cal_busy, w_rx_ltd} = r_sync[SYNC_N-1];

    tx_state_t           r_tx_state;
    tx_state_t           w_tx_state_nxt;
    logic [TX_CNT_W-1:0] r_tx_cnt;
    logic [TX_CNT_W-1:0] w_tx_cnt_nxt;
    logic [TX_CNT_W-1:0] w_tx_cnt_inc;
    logic                w_tx_ok;
    logic                r_tx_analog;
    logic                r_tx_digital;
    logic                r_tx_ready;

    assign w_tx_cnt_inc = (r_tx_cnt == TX_SAT) ? r_tx_cnt : r_tx_cnt + TX_CNT_W'(1);
    assign w_tx_ok      = w_pll_locked & ~|w_tx_cal_busy;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        if (tx_reset_req) begin
            w_tx_state_nxt = T_ANALOG;
            w_tx_cnt_nxt   = '0;
        end else begin
            case (r_tx_state)
                T_ANALOG: begin
                    if (w_tx_cnt_inc == ANA_TERM) begin
                        w_tx_state_nxt = T_WAIT_CAL;
                        w_tx_cnt_nxt   = '0;
                    end else begin
                        w_tx_cnt_nxt = w_tx_cnt_inc;
                    end
                end
                T_WAIT_CAL: begin
                    if (w_tx_ok) begin
                        w_tx_state_nxt = T_WAIT_DIG;
                        w_tx_cnt_nxt   = '0;
                    end
                end
                T_WAIT_DIG: begin
                    // Any lock drop or new calibration restarts the stability window.
                    if (!w_tx_ok) begin
                        w_tx_state_nxt = T_WAIT_CAL;
                        w_tx_cnt_nxt   = '0;
                    end else if (w_tx_cnt_inc == DIG_TERM) begin
                        w_tx_state_nxt = T_READY;
                        w_tx_cnt_nxt   = '0;
                    end else begin
                        w_tx_cnt_nxt = w_tx_cnt_inc;
                    end
                end
                T_READY: begin
                    if (!w_pll_locked) begin
                        w_tx_state_nxt = T_ANALOG;
                        w_tx_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_tx_state_nxt = T_ANALOG;
                    w_tx_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            r_tx_state   <= T_ANALOG;
            r_tx_cnt     <= '0;
            r_tx_analog  <= 1'b1;
            r_tx_digital <= 1'b1;
            r_tx_ready   <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_state_nxt;
            r_tx_cnt     <= w_tx_cnt_nxt;
            r_tx_analog  <= (w_tx_state_nxt == T_ANALOG);
            r_tx_digital <= (w_tx_state_nxt != T_READY);
            r_tx_ready   <= (w_tx_state_nxt == T_READY);
        end
    end

    assign tx_analogreset  = {NUM_CH{r_tx_analog}};
    assign tx_digitalreset = {NUM_CH{r_tx_digital}};
    assign tx_ready        = r_tx_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rx
        gx_rx_reset_fsm #(
            .T_ANALOG_CYC (T_ANALOG_CYC),
            .T_LTD_CYC    (T_LTD_CYC)
        ) u_rx_fsm (
            .i_clk          (reconfig_clk),
            .i_rst          (reconfig_reset),
            .i_reset_req    (rx_reset_req[g]),
            .i_cal_busy     (w_rx_cal_busy[g]),
            .i_locked       (w_rx_ltd[g]),
            .o_analogreset  (rx_analogreset[g]),
            .o_digitalreset (rx_digitalreset[g]),
            .o_ready        (rx_ready[g])
`ifdef GX_RESET_RELOCK_EN
            ,
            .o_relock_cnt   (rx_relock_cnt[8*g +: 8])
`endif
        );
    end

endmodule
